reg_bank_arbiter: RTL and testbench

//   Owns the shared configuration register bank and arbitrates access between
//   two requesters: the I2C slave (host side) and the IO block (chip side).

---
 rtl/reg_arb_pkg.sv | 6 +
 rtl/arb_pick2.sv | 18 +
 rtl/reg_bank_arbiter.sv | 117 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared states, requester ids and limits for reg_bank_arbiter.
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RESP} arb_state_e;
  typedef enum logic {REQ_I2C, REQ_IO} requester_e;
  localparam logic [7:0] CONFLICT_MAX = 8'hFF;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational 2-way picker; req[0]=I2C, req[1]=IO.
// Round-robin when REG_ARB_RR_EN is defined, otherwise I2C has fixed priority.
module arb_pick2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef REG_ARB_RR_EN
  input  requester_e last_winner,
`endif
  output requester_e winner
);
`ifdef REG_ARB_RR_EN
  always_comb winner = (req == 2'b11) ? (last_winner == REQ_I2C ? REQ_IO : REQ_I2C)
                                      : (req[0] ? REQ_I2C : REQ_IO);
`else
  always_comb winner = req[0] ? REQ_I2C : REQ_IO;
`endif
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: register bank shared by I2C and IO requesters, one transaction at a time.
// Define REG_ARB_RR_EN for round-robin arbitration instead of fixed I2C priority.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i2c_req,
  input  logic                       i2c_we,
  input  logic [ADDR_W-1:0]          i2c_addr,
  input  logic [DATA_W-1:0]          i2c_wdata,
  output logic                       i2c_gnt,
  output logic                       i2c_rvalid,
  output logic [DATA_W-1:0]          i2c_rdata,
  input  logic                       io_req,
  input  logic                       io_we,
  input  logic [ADDR_W-1:0]          io_addr,
  input  logic [DATA_W-1:0]          io_wdata,
  output logic                       io_gnt,
  output logic                       io_rvalid,
  output logic [DATA_W-1:0]          io_rdata,
  output logic [NUM_REGS*DATA_W-1:0] registers_packed,
  output logic [7:0]                 conflict_cnt
);
  arb_state_e          state_q, state_d;
  requester_e          who_q, who_d, pick;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   bank_q [NUM_REGS];
  logic [DATA_W-1:0]   bank_d [NUM_REGS];
  logic [DATA_W-1:0]   i2c_rdata_q, i2c_rdata_d, io_rdata_q, io_rdata_d, rd_val;
  logic [7:0]          conflict_q, conflict_d;
  logic [1:0]          req;
  logic                sample, rd_cap;
`ifdef REG_ARB_RR_EN
  requester_e          last_q, last_d;
`endif

  assign req = {io_req, i2c_req};

  arb_pick2 u_pick (
    .req(req),
`ifdef REG_ARB_RR_EN
    .last_winner(last_q),
`endif
    .winner(pick)
  );

  always_comb begin
    sample  = state_q == IDLE && |req;
    rd_cap  = state_q == GRANT && !we_q;
    state_d = state_q == IDLE ? (|req ? GRANT : IDLE) : state_q == GRANT ? RESP : IDLE;
    who_d   = sample ? pick : who_q;
    we_d    = sample ? (pick == REQ_I2C ? i2c_we : io_we) : we_q;
    addr_d  = sample ? (pick == REQ_I2C ? i2c_addr : io_addr) : addr_q;
    wdata_d = sample ? (pick == REQ_I2C ? i2c_wdata : io_wdata) : wdata_q;
    conflict_d = (sample && &req && conflict_q != CONFLICT_MAX) ? conflict_q + 8'd1 : conflict_q;
    // Out-of-range addresses match no entry: writes drop, reads return zero.
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_val    = (addr_q == ADDR_W'(k)) ? bank_q[k] : rd_val;
      bank_d[k] = (state_q == GRANT && we_q && addr_q == ADDR_W'(k)) ? wdata_q : bank_q[k];
    end
    i2c_rdata_d = (rd_cap && who_q == REQ_I2C) ? rd_val : i2c_rdata_q;
    io_rdata_d  = (rd_cap && who_q == REQ_IO) ? rd_val : io_rdata_q;
`ifdef REG_ARB_RR_EN
    last_d = sample ? pick : last_q;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      who_q       <= REQ_I2C;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bank_q      <= '{default: '0};
      i2c_rdata_q <= '0;
      io_rdata_q  <= '0;
      conflict_q  <= '0;
`ifdef REG_ARB_RR_EN
      last_q      <= REQ_IO;
`endif
    end else begin
      state_q     <= state_d;
      who_q       <= who_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bank_q      <= bank_d;
      i2c_rdata_q <= i2c_rdata_d;
      io_rdata_q  <= io_rdata_d;
      conflict_q  <= conflict_d;
`ifdef REG_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign i2c_gnt      = state_q == GRANT && who_q == REQ_I2C;
  assign io_gnt       = state_q == GRANT && who_q == REQ_IO;
  assign i2c_rvalid   = state_q == RESP && !we_q && who_q == REQ_I2C;
  assign io_rvalid    = state_q == RESP && !we_q && who_q == REQ_IO;
  assign i2c_rdata    = i2c_rdata_q;
  assign io_rdata     = io_rdata_q;
  assign conflict_cnt = conflict_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
    assign registers_packed[i*DATA_W +: DATA_W] = bank_q[i];
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and random transactions against a transaction-level model.
module tb_reg_bank_arbiter;
  localparam int NR = 3;
  logic clk = 1'b0, rst;
  logic i2c_req, i2c_we, io_req, io_we;
  logic [1:0] i2c_addr, io_addr;
  logic [7:0] i2c_wdata, io_wdata, i2c_rdata, io_rdata, conflict_cnt;
  logic i2c_gnt, i2c_rvalid, io_gnt, io_rvalid;
  logic [NR*8-1:0] registers_packed;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NUM_REGS(NR), .DATA_W(8), .ADDR_W(2)) dut (
    .clock(clk), .reset(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_gnt(i2c_gnt), .i2c_rvalid(i2c_rvalid), .i2c_rdata(i2c_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .registers_packed(registers_packed), .conflict_cnt(conflict_cnt)
  );

  int checks = 0, failures = 0;
  int cyc, free_at, gnt_at, rv_at, wr_at, gnt_who, rv_who, wr_addr, conf, last;
  logic [7:0] rv_data, wr_data;
  logic [7:0] bank [NR];
  logic [7:0] exp_rd [2];
  logic pend [2], p_we [2];
  logic [1:0] p_addr [2];
  logic [7:0] p_wd [2];
  bit rnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at = 0; gnt_at = -1; rv_at = -1; wr_at = -1; conf = 0; last = 1;
    for (int i = 0; i < NR; i++) bank[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; exp_rd[i] = 8'h00; end
  endtask

  task automatic drive();
    i2c_req = pend[0]; i2c_we = p_we[0]; i2c_addr = p_addr[0]; i2c_wdata = p_wd[0];
    io_req  = pend[1]; io_we  = p_we[1]; io_addr  = p_addr[1]; io_wdata  = p_wd[1];
  endtask

  task automatic post(input int r, input logic we, input logic [1:0] a, input logic [7:0] d);
    pend[r] = 1; p_we[r] = we; p_addr[r] = a; p_wd[r] = d;
  endtask

  task automatic step();
    logic [1:0] r;
    int w;
    r = {io_req, i2c_req};
    @(posedge clk); #1; cyc++;
    if (wr_at == cyc && wr_addr < NR) bank[wr_addr] = wr_data;
    if (cyc >= free_at && r != 2'b00) begin
      if (r == 2'b11) conf = conf < 255 ? conf + 1 : 255;
`ifdef REG_ARB_RR_EN
      w = r == 2'b01 ? 0 : r == 2'b10 ? 1 : (last == 1 ? 0 : 1);
`else
      w = r == 2'b01 ? 0 : 1;
      if (r == 2'b11) w = 0;
`endif
      last = w; gnt_at = cyc; gnt_who = w; free_at = cyc + 3;
      if (p_we[w]) begin
        wr_at = cyc + 1; wr_addr = int'(p_addr[w]); wr_data = p_wd[w];
      end else begin
        rv_at = cyc + 1; rv_who = w;
        rv_data = int'(p_addr[w]) < NR ? bank[p_addr[w]] : 8'h00;
      end
      pend[w] = 0;
    end
    if (rv_at == cyc) exp_rd[rv_who] = rv_data;
    check("i2c_gnt", i2c_gnt, gnt_at == cyc && gnt_who == 0);
    check("io_gnt", io_gnt, gnt_at == cyc && gnt_who == 1);
    check("i2c_rvalid", i2c_rvalid, rv_at == cyc && rv_who == 0);
    check("io_rvalid", io_rvalid, rv_at == cyc && rv_who == 1);
    check("i2c_rdata", i2c_rdata, exp_rd[0]);
    check("io_rdata", io_rdata, exp_rd[1]);
    check("regs", registers_packed, {bank[2], bank[1], bank[0]});
    check("conflict", conflict_cnt, conf);
    if (rnd) for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 2) == 0)
        post(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      else if (pend[i] && $urandom_range(0, 15) == 0)
        pend[i] = 0;
    end
    drive();
  endtask

  initial begin
    rst = 1'b1; cyc = 0; rnd = 0;
    for (int i = 0; i < 2; i++) begin p_we[i] = 0; p_addr[i] = 0; p_wd[i] = 0; end
    model_reset();
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_regs", registers_packed, 0);
    check("rst_gnt", {i2c_gnt, io_gnt, i2c_rvalid, io_rvalid}, 0);
    check("rst_conflict", conflict_cnt, 0);
    @(negedge clk) rst = 1'b0;

    post(0, 1, 2, 8'hA5); drive();
    repeat (4) step();
    check("t1_reg2", registers_packed[23:16], 8'hA5);
    post(1, 0, 2, 8'h00); drive();
    repeat (4) step();
    check("t2_io_rdata", io_rdata, 8'hA5);
    post(0, 1, 0, 8'h11); post(1, 1, 0, 8'h22); drive();
    repeat (8) step();
    check("t3_reg0", registers_packed[7:0], 8'h22);
    check("t3_conflict", conflict_cnt, 1);
    post(0, 1, 3, 8'hFF); drive();
    repeat (4) step();
    check("t5_bank", registers_packed, 24'hA50022);
    post(0, 0, 2, 8'h00); drive();
    repeat (4) step();
    check("t5_rd2", i2c_rdata, 8'hA5);
    post(0, 0, 3, 8'h00); drive();
    repeat (4) step();
    check("t5_rd3", i2c_rdata, 8'h00);

    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    for (int i = 0; i < 2; i++) pend[i] = 0;
    drive();
    repeat (6) step();

    post(0, 1, 1, 8'h77); drive();
    step();
    check("t6_gnt", i2c_gnt, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_gnt", i2c_gnt, 0);
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("t6_rvalid", {i2c_rvalid, io_rvalid}, 0);
    check("t6_regs", registers_packed, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) step();

    repeat (900) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) post(i, 1, 2'($urandom_range(0, 3)), 8'($urandom));
      drive();
      step();
    end
    check("t6_sat", conflict_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
